risc_v_run_ctrl: RTL and testbench

- Parametrised run-control and program-load sequencer for the single-cycle RISC-V core.
- Streams a program into instruction memory through a valid/ready port, then holds the core in reset for one cycle.
- Runs the core until it halts or a cycle budget expires, then reports the outcome.
- Replaces ad-hoc gating of the core reset by a done flag with an explicit FSM. Adds a cycle counter, halt-PC capture, timeout and abort.

---
 rtl/risc_v_run_pkg.sv | 16 +
 rtl/risc_v_imem_loader.sv | 59 +++++
 rtl/risc_v_run_ctrl.sv | 125 ++++++++++++
 tb/tb_risc_v_run_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_run_pkg.sv
// Shared types and constants for the RISC-V run-control sequencer.
package risc_v_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CRST = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } run_state_e;

    localparam logic [31:0] ECALL_INSN        = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INSN       = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_HALT_INSN = ECALL_INSN;

endpackage

// File: rtl/risc_v_imem_loader.sv
// Streams program words into instruction memory through a valid/ready port.
module risc_v_imem_loader #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_start,
    input  logic               load_en,
    input  logic               abort,
    input  logic [IMEM_AW:0]   num_insn,
    input  logic               ld_valid,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               ld_ready,
    output logic               last_word,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata
);

    localparam logic [IMEM_AW:0] DEPTH = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0] ONE   = {{IMEM_AW{1'b0}}, 1'b1};

    logic [IMEM_AW:0] cnt;
    logic [IMEM_AW:0] target;
    logic [IMEM_AW:0] cnt_inc;
    logic             accept;

    // A word transfers on any cycle where ld_valid && ld_ready; the producer
    // holds ld_data stable while ld_valid is high and ld_ready is low.
    assign ld_ready  = load_en & ~abort;
    assign accept    = ld_valid & ld_ready;
    assign cnt_inc   = cnt + ONE;
    assign last_word = accept && (cnt_inc == target);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            target     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (load_start) begin
                cnt    <= '0;
                target <= (num_insn > DEPTH) ? DEPTH : num_insn;
            end else if (accept) begin
                cnt <= cnt_inc;
            end
            imem_we <= accept;
            if (accept) begin
                // cnt stays below DEPTH here, so the low bits never wrap
                imem_addr  <= cnt[IMEM_AW-1:0];
                imem_wdata <= ld_data;
            end
        end
    end

endmodule

// File: rtl/risc_v_run_ctrl.sv
// Run-control FSM: load program, pulse core reset, run until halt or budget.
module risc_v_run_ctrl
    import risc_v_run_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                IMEM_AW   = 8,
    parameter int                PC_W      = 32,
    parameter int                CYC_W     = 32,
    parameter logic [DATA_W-1:0] HALT_INSN = DATA_W'(DEFAULT_HALT_INSN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [IMEM_AW:0]   num_insn,
    input  logic [CYC_W-1:0]   max_cycles,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    input  logic [DATA_W-1:0]  core_insn,
    input  logic [PC_W-1:0]    core_pc,
    output logic               core_reset_n,
    output logic               core_run,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [PC_W-1:0]    halt_pc,
    output logic [CYC_W-1:0]   cycle_cnt,
    output logic [2:0]         dbg_state
);

    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    run_state_e state, state_next;
    logic       start_ok;
    logic       load_start;
    logic       last_word;
    logic       halt_hit;
    logic       budget_hit;
    logic       run_exit;

    assign start_ok   = start & ~abort & ((state == ST_IDLE) | (state == ST_DONE));
    assign load_start = start_ok & (num_insn != '0);
    assign halt_hit   = (core_insn == HALT_INSN);
    assign budget_hit = (max_cycles != '0) && ((cycle_cnt + CYC_ONE) == max_cycles);
    assign run_exit   = (state == ST_RUN) && (halt_hit || budget_hit);

    risc_v_imem_loader #(
        .DATA_W  (DATA_W),
        .IMEM_AW (IMEM_AW)
    ) u_loader (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_en    (state == ST_LOAD),
        .abort      (abort),
        .num_insn   (num_insn),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .last_word  (last_word),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = (num_insn != '0) ? ST_LOAD : ST_CRST;
                end
            end
            ST_LOAD: if (last_word) state_next = ST_CRST;
            ST_CRST: state_next = ST_RUN;
            ST_RUN:  if (halt_hit || budget_hit) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done      <= 1'b0;
            timeout   <= 1'b0;
            halt_pc   <= '0;
            cycle_cnt <= '0;
        end else begin
            if (state == ST_CRST) begin
                cycle_cnt <= '0;
            end else if ((state == ST_RUN) && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + CYC_ONE;
            end
            if (abort || start_ok) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end else if (run_exit) begin
                // a halt seen on the budget's last cycle still counts as a clean halt
                done    <= 1'b1;
                timeout <= ~halt_hit;
                halt_pc <= core_pc;
            end
        end
    end

    assign core_reset_n = (state == ST_RUN);
    assign core_run     = (state == ST_RUN);
    assign running      = (state == ST_RUN);
    assign dbg_state    = state;

endmodule

// File: tb/tb_risc_v_run_ctrl.sv
// Directed self-checking bench for risc_v_run_ctrl with a write scoreboard.
module tb_risc_v_run_ctrl;
    import risc_v_run_pkg::*;

    localparam int DATA_W  = 32;
    localparam int IMEM_AW = 4;
    localparam int PC_W    = 32;
    localparam int CYC_W   = 32;
    localparam logic [DATA_W-1:0] HALT = 32'h0000_0073;
    localparam logic [DATA_W-1:0] NOP  = 32'h0000_0013;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               abort;
    logic [IMEM_AW:0]   num_insn;
    logic [CYC_W-1:0]   max_cycles;
    logic               ld_valid;
    logic               ld_ready;
    logic [DATA_W-1:0]  ld_data;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DATA_W-1:0]  imem_wdata;
    logic [DATA_W-1:0]  core_insn;
    logic [PC_W-1:0]    core_pc;
    logic               core_reset_n;
    logic               core_run;
    logic               running;
    logic               done;
    logic               timeout;
    logic [PC_W-1:0]    halt_pc;
    logic [CYC_W-1:0]   cycle_cnt;
    logic [2:0]         dbg_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int ld_idx = 0;
    logic [IMEM_AW-1:0] last_addr = '0;
    logic [IMEM_AW+DATA_W-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    risc_v_run_ctrl #(
        .DATA_W  (DATA_W),
        .IMEM_AW (IMEM_AW),
        .PC_W    (PC_W),
        .CYC_W   (CYC_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .num_insn     (num_insn),
        .max_cycles   (max_cycles),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_insn    (core_insn),
        .core_pc      (core_pc),
        .core_reset_n (core_reset_n),
        .core_run     (core_run),
        .running      (running),
        .done         (done),
        .timeout      (timeout),
        .halt_pc      (halt_pc),
        .cycle_cnt    (cycle_cnt),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic give_start(input logic [IMEM_AW:0] n, input logic [CYC_W-1:0] mc);
        start      = 1'b1;
        num_insn   = n;
        max_cycles = mc;
        ld_idx     = 0;
        step();
        start = 1'b0;
    endtask

    task automatic offer_word();
        ld_valid = 1'b1;
        ld_data  = $urandom;
        if (ld_ready) begin
            exp_q.push_back({IMEM_AW'(ld_idx), ld_data});
            ld_idx++;
        end
        step();
    endtask

    // scoreboard: each observed write must match the oldest accepted word
    always @(negedge clk) begin
        if (reset_n && imem_we) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(imem_addr), 64'hFFFF);
            end else begin
                logic [IMEM_AW+DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e[IMEM_AW+DATA_W-1:DATA_W]));
                chk("wr_data", 64'(imem_wdata), 64'(e[DATA_W-1:0]));
            end
            wr_cnt++;
            last_addr = imem_addr;
        end
    end

    initial begin
        int wr_base;
        int run_n;
        int n;

        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        num_insn   = '0;
        max_cycles = '0;
        core_insn  = NOP;
        core_pc    = '0;
        step();
        step();
        chk("rst_ctl", {ld_ready, imem_we, core_run, running, done, timeout, core_reset_n}, 64'h0);
        chk("rst_addr", 64'(imem_addr), 64'h0);
        chk("rst_wdata", 64'(imem_wdata), 64'h0);
        chk("rst_halt_pc", 64'(halt_pc), 64'h0);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'h0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        reset_n = 1'b1;
        step();

        // load three words back-to-back, halt on 5th run cycle
        give_start(5'd3, '0);
        chk("t1_ready", 64'(ld_ready), 64'h1);
        for (int i = 0; i < 3; i++) offer_word();
        ld_valid = 1'b0;
        chk("t1_crst_state", 64'(dbg_state), 64'(ST_CRST));
        chk("t1_crst_rst", {core_reset_n, running}, 64'h0);
        step();
        chk("t1_run_ctl", {core_reset_n, core_run, running}, 64'h7);
        chk("t1_run_cnt0", 64'(cycle_cnt), 64'h0);
        for (int i = 0; i < 4; i++) step();
        core_insn = HALT;
        core_pc   = 32'h0000_0140;
        step();
        core_insn = NOP;
        chk("t1_done", {done, timeout}, 64'h2);
        chk("t1_cycle_cnt", 64'(cycle_cnt), 64'd5);
        chk("t1_halt_pc", 64'(halt_pc), 64'h140);
        chk("t1_core_held", {core_reset_n, running}, 64'h0);
        chk("t1_writes", 64'(wr_cnt), 64'd3);
        chk("t1_q_empty", 64'(exp_q.size()), 64'h0);
        core_pc = 32'h0000_0999;
        step();
        chk("t1_frozen_cnt", 64'(cycle_cnt), 64'd5);
        chk("t1_frozen_pc", 64'(halt_pc), 64'h140);

        // gapped load from DONE
        wr_base = wr_cnt;
        give_start(5'd3, '0);
        chk("t2_done_clr", {done, timeout}, 64'h0);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                offer_word();
            end else begin
                ld_valid = 1'b0;
                step();
            end
            if (i < 4) chk("t2_in_load", 64'(dbg_state), 64'(ST_LOAD));
        end
        ld_valid = 1'b0;
        chk("t2_crst", 64'(dbg_state), 64'(ST_CRST));
        step();
        chk("t2_writes", 64'(wr_cnt - wr_base), 64'd3);
        core_insn = HALT;
        core_pc   = 32'h0000_0008;
        step();
        core_insn = NOP;
        chk("t2_done", {done, timeout}, 64'h2);
        chk("t2_cycle_cnt", 64'(cycle_cnt), 64'd1);

        // timeout with no load
        give_start('0, 32'd10);
        chk("t3_crst", 64'(dbg_state), 64'(ST_CRST));
        chk("t3_no_ready", {ld_ready, imem_we}, 64'h0);
        step();
        run_n = 0;
        for (int i = 0; i < 40 && running; i++) begin
            run_n++;
            step();
        end
        chk("t3_run_cycles", 64'(run_n), 64'd10);
        chk("t3_done", {done, timeout}, 64'h3);
        chk("t3_cycle_cnt", 64'(cycle_cnt), 64'd10);

        // halt on the cycle the budget expires
        give_start('0, 32'd3);
        step();
        step();
        step();
        chk("t4_pre", {running, 1'b0}, 64'h2);
        chk("t4_pre_cnt", 64'(cycle_cnt), 64'd2);
        core_insn = HALT;
        core_pc   = 32'h0000_002c;
        step();
        core_insn = NOP;
        chk("t4_done", {done, timeout}, 64'h2);
        chk("t4_cycle_cnt", 64'(cycle_cnt), 64'd3);
        chk("t4_halt_pc", 64'(halt_pc), 64'h2c);

        // abort in RUN at cycle 4, restart, start ignored in RUN
        give_start('0, '0);
        for (int i = 0; i < 4; i++) step();
        chk("t5_cnt_c4", 64'(cycle_cnt), 64'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("t5_flags", {done, timeout, core_reset_n, running}, 64'h0);
        give_start('0, '0);
        step();
        chk("t5_restart_cnt", 64'(cycle_cnt), 64'd0);
        give_start(5'd5, '0);
        chk("t5_ign_state", 64'(dbg_state), 64'(ST_RUN));
        chk("t5_ign_ready", 64'(ld_ready), 64'h0);
        chk("t5_ign_cnt", 64'(cycle_cnt), 64'd1);
        core_insn = HALT;
        step();
        core_insn = NOP;
        chk("t5_done", {done, timeout}, 64'h2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_done", {done, 64'(dbg_state)}, 64'(ST_IDLE));

        // clamp: request DEPTH+5 words, offer continuously
        wr_base = wr_cnt;
        give_start(5'd21, '0);
        n = 0;
        while (ld_ready && n < 40) begin
            offer_word();
            n++;
        end
        ld_valid = 1'b0;
        chk("t6_accepted", 64'(n), 64'd16);
        chk("t6_crst", 64'(dbg_state), 64'(ST_CRST));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_writes", 64'(wr_cnt - wr_base), 64'd16);
        chk("t6_last_addr", 64'(last_addr), 64'hF);
        chk("t6_q_empty", 64'(exp_q.size()), 64'h0);
        chk("t6_idle_we", 64'(imem_we), 64'h0);

        // asynchronous reset in the middle of a load
        give_start(5'd5, '0);
        offer_word();
        offer_word();
        chk("t7_pre_we", {imem_we, ld_ready}, 64'h3);
        ld_valid = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        chk("t7_async_ctl", {ld_ready, imem_we, core_reset_n}, 64'h0);
        chk("t7_async_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("t7_async_addr", 64'(imem_addr), 64'h0);
        ld_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("t7_q_empty", 64'(exp_q.size()), 64'h0);
        chk("t7_idle", 64'(dbg_state), 64'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
